// File: rtl/hyp_share_pkg.sv
// hyp_share_pkg: shared types and helpers for the hypotenuse-engine sharing
// controller and its round-robin arbiter.
//   state_t  - controller FSM states
//   DEF_W    - default operand width
//   DEF_RW   - default result width (holds floor(sqrt(2*255^2)) = 360)
//   id_w()   - width of a requester ID for n requesters (never below 1)
package hyp_share_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  localparam int DEF_W  = 8;
  localparam int DEF_RW = 9;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hyp_rr_arbiter.sv
// hyp_rr_arbiter: purely combinational round-robin arbiter.
// The search starts at (last+1) mod N and wraps, so the most recently served
// requester has the lowest priority.
//   req     in   N        request vector
//   last    in   id_w(N)  most recently served requester
//   gnt     out  N        one-hot grant (zero when no request)
//   gnt_id  out  id_w(N)  encoded grant
//   any_gnt out  1        some requester was granted
module hyp_rr_arbiter
  import hyp_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  last,
  output logic [N-1:0]        gnt,
  output logic [id_w(N)-1:0]  gnt_id,
  output logic                any_gnt
);

  localparam int IW = id_w(N);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyp_share_ctrl.sv
// hyp_share_ctrl: shares one start/busy/result hypotenuse engine among N_REQ
// requesters. One operand pair is accepted at a time (round-robin), the engine
// is started and waited on, and the result goes back tagged with the owner ID.
// A bounded wait turns a stuck engine into a timeout response.
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_x/req_y           packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_result     owner and result (result 0 on timeout)
//   rsp_timeout           engine did not finish inside TIMEOUT cycles
//   eng_start             one-cycle start pulse
//   eng_x/eng_y           latched operands, stable from ISSUE until IDLE
//   eng_busy/eng_result   engine status; result valid when busy falls
module hyp_share_ctrl
  import hyp_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = DEF_W,
  parameter int RW      = DEF_RW,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W-1:0]      req_x,
  input  logic [N_REQ*W-1:0]      req_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [id_w(N_REQ)-1:0]  rsp_id,
  output logic [RW-1:0]           rsp_result,
  output logic                    rsp_timeout,
  output logic                    eng_start,
  output logic [W-1:0]            eng_x,
  output logic [W-1:0]            eng_y,
  input  logic                    eng_busy,
  input  logic [RW-1:0]           eng_result
);

  localparam int IW = id_w(N_REQ);
  // One spare bit: the counter may step one past TIMEOUT-1 when WAIT_BUSY
  // exits on its last allowed cycle, and must not wrap back to zero.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [RW-1:0]   rsp_result_q, rsp_result_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [W-1:0]    eng_x_q, eng_x_d;
  logic [W-1:0]    eng_y_q, eng_y_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             any_gnt;

  hyp_rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    eng_x_d       = eng_x_q;
    eng_y_d       = eng_y_q;
    cnt_d         = cnt_q;
    req_ready     = '0;
    eng_start     = 1'b0;
    rsp_valid     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = gnt;
        if (any_gnt) begin
          eng_x_d  = req_x[gnt_id*W +: W];
          eng_y_d  = req_y[gnt_id*W +: W];
          rsp_id_d = gnt_id;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (eng_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESPOND;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (!eng_busy) begin
          rsp_result_d  = eng_result;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESPOND;
        end else if (cnt_q >= CNT_LAST) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESPOND;
        end
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_d  = rsp_id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= IW'(N_REQ - 1);
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      eng_x_q       <= eng_x_d;
      eng_y_q       <= eng_y_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign eng_x       = eng_x_q;
  assign eng_y       = eng_y_q;

endmodule

// File: tb/tb_hyp_share_ctrl.sv
// tb_hyp_share_ctrl: bench for hyp_share_ctrl. A transaction-level model
// predicts every output each cycle from the accept time, the engine's busy
// history and the round-robin rule; directed scenarios pin it with literals,
// then a randomized run exercises requesters, engine latency and backpressure.
module tb_hyp_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 9;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*W-1:0]  req_x = '0, req_y = '0;
  logic            rsp_valid, rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_result;
  logic            rsp_timeout, eng_start;
  logic [W-1:0]    eng_x, eng_y;
  logic            eng_busy = 1'b0;
  logic [RW-1:0]   eng_result = '0;

  always #5 clk = ~clk;

  hyp_share_ctrl #(.N_REQ(N), .W(W), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_busy(eng_busy), .eng_result(eng_result)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // requesters
  bit         pend[N];
  logic [W-1:0] px[N], py[N];
  bit sticky = 0, rnd_req = 0, rnd_rdy = 0, rnd_eng = 0;
  bit tb_rst = 1, tb_rdy = 1;

  // engine
  int e_t0 = -1, e_dly = 0, e_len = 1;
  bit e_dead = 0;
  logic [W-1:0] ex = '0, ey = '0;
  bit nx_dead = 0;
  int nx_dly = 1, nx_len = 3;

  // model
  bit m_ok = 0, m_to = 0;
  int m_ph = 0, m_last = N - 1, m_id = 0, m_A = 0, m_E = 0, m_B = -1, m_res = 0;
  logic [W-1:0] m_x = '0, m_y = '0;

  // observations for literal checks
  int lg_id[$], lg_res[$], lg_to[$];
  int first_start = -1, first_rv = -1, first_rdy = -1, rv_cnt = 0;

  task automatic step();
    logic [N-1:0] exp_rdy;
    int grant;
    bit ex_now;
    @(posedge clk); #1;
    cyc++;
    rst       = tb_rst;
    rsp_ready = tb_rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_x[i*W +: W]  = px[i];
      req_y[i*W +: W]  = py[i];
    end
    if (e_t0 >= 0 && !e_dead) begin
      int bs;
      bs = e_t0 + 1 + e_dly;
      eng_busy   = (cyc >= bs) && (cyc < bs + e_len);
      eng_result = (cyc >= bs + e_len) ? RW'(isqrt(int'(ex) * int'(ex) + int'(ey) * int'(ey)))
                                       : RW'($urandom);
    end else begin
      eng_busy   = 1'b0;
      eng_result = RW'($urandom);
    end
    #4;

    grant   = -1;
    exp_rdy = '0;
    if (m_ok) begin
      if (m_ph == 0)
        for (int k = 1; k <= N; k++)
          if (grant < 0 && req_valid[(m_last + k) % N]) grant = (m_last + k) % N;
      if (grant >= 0) exp_rdy[grant] = 1'b1;
      chk("req_ready",   32'(req_ready), 32'(exp_rdy));
      chk("eng_start",   32'(eng_start), 32'(m_ph == 1 && cyc == m_A + 1));
      chk("rsp_valid",   32'(rsp_valid), 32'(m_ph == 2));
      chk("rsp_id",      32'(rsp_id), m_id);
      chk("rsp_result",  32'(rsp_result), m_res);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      chk("eng_x",       32'(eng_x), 32'(m_x));
      chk("eng_y",       32'(eng_y), 32'(m_y));
    end

    if (eng_start && !rst) begin
      if (first_start < 0) first_start = cyc;
      if (rnd_eng) begin
        nx_dead = ($urandom % 20) == 0;
        nx_dly  = $urandom % 4;
        nx_len  = (($urandom % 25) == 0) ? 56 + $urandom % 10 : 1 + $urandom % 6;
      end
      e_t0 = cyc; ex = eng_x; ey = eng_y;
      e_dead = nx_dead; e_dly = nx_dly; e_len = nx_len;
    end
    if (rsp_valid) begin
      rv_cnt++;
      if (first_rv < 0) first_rv = cyc;
    end
    if ((|req_ready) && first_rdy < 0) first_rdy = cyc;
    if (rsp_valid && rsp_ready && !rst) begin
      lg_id.push_back(int'(rsp_id));
      lg_res.push_back(int'(rsp_result));
      lg_to.push_back(int'(rsp_timeout));
    end

    // model advance
    if (rst) begin
      m_ok = 1; m_ph = 0; m_last = N - 1; m_id = 0;
      m_x = '0; m_y = '0; m_res = 0; m_to = 0;
    end else if (m_ok) begin
      case (m_ph)
        0: if (grant >= 0) begin
             m_ph = 1; m_id = grant; m_x = px[grant]; m_y = py[grant];
             m_A = cyc; m_E = cyc + 2; m_B = -1;
           end
        1: if (cyc >= m_E) begin
             ex_now = 0;
             if (m_B < 0 && eng_busy) begin
               m_B = cyc; ex_now = 1;
             end else if (m_B >= 0 && !eng_busy) begin
               m_res = isqrt(int'(m_x) * int'(m_x) + int'(m_y) * int'(m_y));
               m_to = 0; m_ph = 2; ex_now = 1;
             end
             if (!ex_now && cyc >= m_E + TO - 1) begin
               m_res = 0; m_to = 1; m_ph = 2;
             end
           end
        default: if (rsp_ready) begin
             m_ph = 0; m_last = m_id;
           end
      endcase
    end

    if (rst) e_t0 = -1;
    for (int i = 0; i < N; i++) begin
      if (!rst && req_ready[i] && pend[i] && !sticky) pend[i] = 0;
      if (rnd_req) begin
        if (!pend[i] && ($urandom % 6) == 0) begin
          pend[i] = 1; px[i] = W'($urandom); py[i] = W'($urandom);
        end else if (pend[i] && ($urandom % 50) == 0) begin
          pend[i] = 0;
        end
      end
    end
    if (rnd_rdy) tb_rdy = ($urandom % 4) != 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    tb_rst = 1; tb_rdy = 1; sticky = 0;
    nx_dead = 0; nx_dly = 1; nx_len = 3;
    step(); step();
    tb_rst = 0;
    lg_id.delete(); lg_res.delete(); lg_to.delete();
    first_start = -1; first_rv = -1; first_rdy = -1; rv_cnt = 0;
  endtask

  task automatic wait_logs(input int n, input int budget);
    for (int k = 0; k < budget && lg_id.size() < n; k++) step();
    if (lg_id.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL wait_rsp cyc=%0d got=%0d responses want=%0d", cyc, lg_id.size(), n);
    end
  endtask

  task automatic chk_log(input int k, input int id, input int res, input int to);
    if (k >= lg_id.size()) begin
      n_vec++; n_bad++;
      $display("FAIL log_missing entry=%0d got=%0d entries", k, lg_id.size());
    end else begin
      chk($sformatf("log%0d_id", k), lg_id[k], id);
      chk($sformatf("log%0d_res", k), lg_res[k], res);
      chk($sformatf("log%0d_to", k), lg_to[k], to);
    end
  endtask

  task automatic set_req(input int i, input int x, input int y);
    pend[i] = 1; px[i] = W'(x); py[i] = W'(y);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 0; px[i] = '0; py[i] = '0; end

    // reset state
    do_reset();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_eng_x", 32'(eng_x), 0);

    // single request
    set_req(1, 3, 4);
    wait_logs(1, 200);
    chk_log(0, 1, 5, 0);
    chk("start_latency", first_start - first_rdy, 1);

    // simultaneous requests
    do_reset();
    set_req(0, 5, 12); set_req(2, 7, 24);
    wait_logs(2, 300);
    chk_log(0, 0, 13, 0); chk_log(1, 2, 25, 0);

    // fairness
    do_reset();
    sticky = 1;
    set_req(0, 8, 15); set_req(1, 16, 63); set_req(2, 3, 4); set_req(3, 5, 12);
    wait_logs(6, 600);
    chk_log(0, 0, 17, 0); chk_log(1, 1, 65, 0); chk_log(2, 2, 5, 0);
    chk_log(3, 3, 13, 0); chk_log(4, 0, 17, 0); chk_log(5, 1, 65, 0);

    // backpressure
    do_reset();
    set_req(0, 8, 15); set_req(3, 3, 4);
    tb_rdy = 0;
    for (int k = 0; k < 100 && !rsp_valid; k++) step();
    for (int k = 0; k < 4; k++) step();
    tb_rdy = 1;
    step();
    chk("bp_valid_cycles", rv_cnt, 6);
    step();
    chk("bp_valid_drop", 32'(rsp_valid), 0);
    wait_logs(2, 300);
    chk_log(0, 0, 17, 0); chk_log(1, 3, 5, 0);

    // timeout, then normal recovery
    do_reset();
    nx_dead = 1;
    set_req(2, 6, 8);
    wait_logs(1, 300);
    chk_log(0, 2, 0, 1);
    chk("to_latency", first_rv - first_start, 65);
    nx_dead = 0;
    set_req(1, 9, 12);
    wait_logs(2, 300);
    chk_log(1, 1, 15, 0);

    // completion on the last allowed wait cycle vs one cycle too late
    do_reset();
    nx_dly = 0; nx_len = 63;
    set_req(0, 20, 21);
    wait_logs(1, 300);
    chk_log(0, 0, 29, 0);
    nx_len = 64;
    set_req(1, 20, 21);
    wait_logs(2, 300);
    chk_log(1, 1, 0, 1);

    // reset during WAIT_DONE
    do_reset();
    set_req(0, 8, 15);
    wait_logs(1, 200);
    nx_len = 40;
    set_req(2, 5, 12);
    for (int k = 0; k < 100 && !eng_busy; k++) step();
    for (int k = 0; k < 4; k++) step();
    tb_rst = 1;
    step();
    tb_rst = 0;
    nx_len = 3;
    lg_id.delete(); lg_res.delete(); lg_to.delete();
    set_req(0, 3, 4); set_req(1, 6, 8);
    step();
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_result", 32'(rsp_result), 0);
    chk("mid_rst_eng_x", 32'(eng_x), 0);
    chk("mid_rst_start", 32'(eng_start), 0);
    wait_logs(2, 300);
    chk_log(0, 0, 5, 0); chk_log(1, 1, 10, 0);

    // randomized run
    do_reset();
    rnd_req = 1; rnd_rdy = 1; rnd_eng = 1;
    for (int k = 0; k < 6000; k++) begin
      tb_rst = ($urandom % 400) == 0;
      step();
    end
    tb_rst = 0;
    chk("rnd_activity", 32'(lg_id.size() > 20), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
